// File: rtl/mem_arbiter_pkg.sv
// Shared types for the N-master memory bus arbiter.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational request picker: rotating priority from a pointer, or fixed
// priority with index 0 highest.
module rr_priority_picker #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               rr_mode,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Scan candidates in priority order; the first requester found wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    winner   = '0;
    valid    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = rr_mode ? (int'(ptr) + k) % NUM_REQ : k;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid  = 1'b1;
        winner = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-master to single-slave memory bus arbiter with round-robin or fixed
// priority and per-master bus lock for atomic sequences.
module mem_arbiter_n
  import mem_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 3,
  parameter  int ADDR_WIDTH  = 19,
  parameter  int DATA_WIDTH  = 16,
  parameter  int ROUND_ROBIN = 1,
  localparam int BYTES       = DATA_WIDTH / 8,
  localparam int GRANT_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
  input  logic [NUM_MASTERS-1:0]            m_wr_en,
  input  logic [NUM_MASTERS*BYTES-1:0]      m_bytesel,
  input  logic [NUM_MASTERS-1:0]            m_access,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [DATA_WIDTH-1:0]             m_data_in,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_data_out,
  input  logic [DATA_WIDTH-1:0]             s_data_in,
  output logic                              s_access,
  input  logic                              s_ack,
  output logic                              s_wr_en,
  output logic [BYTES-1:0]                  s_bytesel,
  output logic [GRANT_W-1:0]                grant_id,
  output logic                              busy
);

  localparam logic [GRANT_W-1:0] LAST_ID = GRANT_W'(NUM_MASTERS - 1);

  arb_state_t         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] pick_idx;
  logic [GRANT_W-1:0] after_grant;
  logic               pick_valid;
  logic               release_bus;

  logic [ADDR_WIDTH-1:0] addr_slice  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] data_slice  [NUM_MASTERS];
  logic [BYTES-1:0]      bytes_slice [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
    assign addr_slice[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_slice[i]  = m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
    assign bytes_slice[i] = m_bytesel[i*BYTES +: BYTES];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_MASTERS)
  ) u_picker (
    .req     (m_access),
    .ptr     (ptr_q),
    .rr_mode (ROUND_ROBIN != 0),
    .winner  (pick_idx),
    .valid   (pick_valid)
  );

  // Slave-side mux follows the registered grant even in IDLE; s_access qualifies it.
  assign busy       = (state_q == ACTIVE);
  assign grant_id   = grant_q;
  assign s_access   = busy & m_access[grant_q];
  assign s_addr     = addr_slice[grant_q];
  assign s_data_out = data_slice[grant_q];
  assign s_bytesel  = bytes_slice[grant_q];
  assign s_wr_en    = m_wr_en[grant_q];
  assign m_data_in  = s_data_in;

  assign after_grant = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  // An unlocked master gives up the bus on completion or when it withdraws its request.
  assign release_bus = !m_lock[grant_q] && (s_ack || !m_access[grant_q]);

  always_comb begin
    m_ack          = '0;
    m_ack[grant_q] = s_ack & s_access;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (release_bus) begin
          state_d = IDLE;
          ptr_d   = after_grant;
        end
      end
    endcase
  end

endmodule
